// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Purpose : Valid/ready configuration channel for the clk_div_ctrl divider.
//           The host (master) offers a new divide value plus a run/stop flag.
//           The divider (slave) takes the request in any cycle where both
//           cfg_valid and cfg_ready are high.
// Signals :
//   cfg_valid  master->slave  request valid
//   cfg_ready  slave->master  divider can take a request this cycle
//   cfg_div    master->slave  new divide value (half-period minus one)
//   cfg_en     master->slave  1 = run with cfg_div, 0 = stop the output
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_en;

   // Host side drives the request fields and watches ready.
   modport master (
      output cfg_valid,
      output cfg_div,
      output cfg_en,
      input  cfg_ready
   );

   // Divider side consumes the request fields and drives ready.
   modport slave (
      input  cfg_valid,
      input  cfg_div,
      input  cfg_en,
      output cfg_ready
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Purpose : Run-time controller for a counter-based clock divider.
//           It owns the divide counter and accepts new divide ratios and
//           run/stop requests over a valid/ready channel. A new setting only
//           takes effect once the current output period has completed
//           (on the high->low edge of o_clk_out), so the divided clock never
//           produces a runt pulse.
// Parameters :
//   WIDTH        width of the divide value and the internal counter
//   DEFAULT_DIV  divide value loaded at reset (half-period = DEFAULT_DIV+1)
//   START_EN     1 = come out of reset already running, 0 = come out stopped
// Ports :
//   i_clk_in   system clock
//   i_rst      asynchronous reset, active high
//   i_ce       count enable; counter and output freeze while low
//   cfg        configuration channel (slave side of clk_div_ctrl_if)
//   o_clk_out  divided clock, registered
//   o_tick     one-cycle pulse in the cycle o_clk_out has just risen
//   o_busy     high while a request is pending or being loaded
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = '0,
   parameter bit               START_EN    = 1'b0
) (
   input  logic          i_clk_in,
   input  logic          i_rst,
   input  logic          i_ce,
   clk_div_ctrl_if.slave cfg,
   output logic          o_clk_out,
   output logic          o_tick,
   output logic          o_busy
);

   // OFF  : output parked low, counter cleared, waiting for a run request.
   // RUN  : dividing with the current ratio, ready for a request.
   // PEND : a request is held in the shadow, still dividing with the old
   //        ratio until the current period ends.
   // LOAD : single cycle that copies the shadow ratio in and restarts.
   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2,
      S_LOAD = 2'd3
   } state_t;

   localparam state_t RESET_STATE = START_EN ? S_RUN : S_OFF;

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_divReg;
   logic [WIDTH-1:0] r_shadowDiv;
   logic             r_shadowEn;
   logic             r_clkOut;
   logic             r_tick;
   logic             r_ready;
   logic             r_busy;

   logic             w_accept;
   logic             w_step;
   logic             w_wrap;
   logic             w_rise;
   logic             w_fall;
   logic             w_readyNext;
   logic             w_tickNext;

   // A request is taken whenever the host offers one while we are ready.
   // Ready is a register that always mirrors "state is OFF or RUN", so this
   // handshake is equivalent to checking the current state directly.
   assign w_accept = cfg.cfg_valid & r_ready;

   // A divide step happens only while dividing and enabled. The counter is
   // compared for equality only, so a divide value of all ones is legal and
   // the counter never has to go past it.
   assign w_step = i_ce & ((r_state == S_RUN) | (r_state == S_PEND));
   assign w_wrap = w_step & (r_cnt == r_divReg);
   assign w_rise = w_wrap & ~r_clkOut;
   assign w_fall = w_wrap &  r_clkOut;

   // State register. Reset drops any pending request on the floor because
   // the shadow is also cleared and the state leaves PEND.
   always_ff @(posedge i_clk_in or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. In RUN the accept cycle still divides with the old
   // ratio, and because the move to PEND only lands on the next edge, a
   // falling step in that same accept cycle cannot end the pending period.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_OFF: begin
            if (w_accept && cfg.cfg_en) begin
               w_nextState = S_LOAD;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               w_nextState = S_PEND;
            end
         end
         S_PEND: begin
            if (w_fall) begin
               w_nextState = r_shadowEn ? S_LOAD : S_OFF;
            end
         end
         S_LOAD: begin
            w_nextState = S_RUN;
         end
         default: begin
            w_nextState = RESET_STATE;
         end
      endcase
   end

   // Output decode, computed one cycle early from the next state so that
   // ready, busy and tick all leave the block straight from flops.
   always_comb begin
      w_readyNext = 1'b0;
      w_tickNext  = 1'b0;
      if ((w_nextState == S_OFF) || (w_nextState == S_RUN)) begin
         w_readyNext = 1'b1;
      end
      w_tickNext = w_rise;
   end

   // Datapath: shadow capture, divide counter, ratio register and the
   // registered outputs.
   always_ff @(posedge i_clk_in or posedge i_rst) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_divReg    <= DEFAULT_DIV;
         r_shadowDiv <= '0;
         r_shadowEn  <= 1'b0;
         r_clkOut    <= 1'b0;
         r_tick      <= 1'b0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_tick  <= w_tickNext;
         r_ready <= w_readyNext;
         r_busy  <= ~w_readyNext;

         if (w_accept) begin
            r_shadowDiv <= cfg.cfg_div;
            r_shadowEn  <= cfg.cfg_en;
         end

         case (r_state)
            S_OFF: begin
               r_cnt    <= '0;
               r_clkOut <= 1'b0;
               // A stop request while already stopped just updates the ratio.
               if (w_accept && !cfg.cfg_en) begin
                  r_divReg <= cfg.cfg_div;
               end
            end
            S_RUN, S_PEND: begin
               if (w_step) begin
                  if (r_cnt == r_divReg) begin
                     r_cnt    <= '0;
                     r_clkOut <= ~r_clkOut;
                  end else begin
                     r_cnt <= r_cnt + WIDTH'(1);
                  end
               end
               // A pending stop request keeps its ratio for the next start.
               if ((r_state == S_PEND) && w_fall && !r_shadowEn) begin
                  r_divReg <= r_shadowDiv;
               end
            end
            S_LOAD: begin
               r_divReg <= r_shadowDiv;
               r_cnt    <= '0;
               r_clkOut <= 1'b0;
            end
            default: begin
               r_cnt    <= '0;
               r_clkOut <= 1'b0;
            end
         endcase
      end
   end

   assign cfg.cfg_ready = r_ready;
   assign o_clk_out     = r_clkOut;
   assign o_tick        = r_tick;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Purpose : Self-checking bench for clk_div_ctrl. Two instances share clock,
//           reset and ce: dutA (stopped at reset, default ratio 0) takes all
//           configuration traffic; dutB (running at reset, default ratio 2)
//           never gets a request and shows the reset ratio on its output.
//           A behavioural model tracks each instance as "ce-cycles left in
//           the current half-period" and is compared every clock.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic ce;
   logic clkOutA, tickA, busyA;
   logic clkOutB, tickB, busyB;

   int errors = 0;
   int checks = 0;

   // Model state per instance: 0 OFF, 1 RUN, 2 PEND, 3 LOAD.
   int mState [2];
   int mDiv   [2];
   int mLeft  [2];
   int mShDiv [2];
   bit mShEn  [2];
   bit mOut   [2];
   bit mTick  [2];
   int defDiv [2] = '{0, 2};
   int startSt[2] = '{0, 1};

   always #5 clk = ~clk;

   clk_div_ctrl_if #(.WIDTH(W)) cfgA ();
   clk_div_ctrl_if #(.WIDTH(W)) cfgB ();

   clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(8'd0), .START_EN(1'b0)) dutA (
      .i_clk_in (clk),
      .i_rst    (rst),
      .i_ce     (ce),
      .cfg      (cfgA),
      .o_clk_out(clkOutA),
      .o_tick   (tickA),
      .o_busy   (busyA)
   );

   clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(8'd2), .START_EN(1'b1)) dutB (
      .i_clk_in (clk),
      .i_rst    (rst),
      .i_ce     (ce),
      .cfg      (cfgB),
      .o_clk_out(clkOutB),
      .o_tick   (tickB),
      .o_busy   (busyB)
   );

   // Bring the model back to its reset picture.
   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mState[k] = startSt[k];
         mDiv[k]   = defDiv[k];
         mLeft[k]  = defDiv[k] + 1;
         mShDiv[k] = 0;
         mShEn[k]  = 1'b0;
         mOut[k]   = 1'b0;
         mTick[k]  = 1'b0;
      end
   endtask

   // Advance one instance of the model by one clock edge.
   task automatic modelEdge(int k, bit ceV, bit validV, int divV, bit enV);
      bit accept;
      bit fell;
      accept   = validV && (mState[k] == 0 || mState[k] == 1);
      fell     = 1'b0;
      mTick[k] = 1'b0;
      case (mState[k])
         0: begin
            mOut[k] = 1'b0;
            if (accept) begin
               mShDiv[k] = divV;
               mShEn[k]  = enV;
               if (enV) mState[k] = 3;
               else     mDiv[k]   = divV;
            end
            mLeft[k] = mDiv[k] + 1;
         end
         1, 2: begin
            if (ceV) begin
               mLeft[k] = mLeft[k] - 1;
               if (mLeft[k] == 0) begin
                  mOut[k]  = !mOut[k];
                  mLeft[k] = mDiv[k] + 1;
                  if (mOut[k]) mTick[k] = 1'b1;
                  else         fell     = 1'b1;
               end
            end
            if (mState[k] == 2 && fell) begin
               if (mShEn[k]) begin
                  mState[k] = 3;
               end else begin
                  mState[k] = 0;
                  mDiv[k]   = mShDiv[k];
               end
            end else if (mState[k] == 1 && accept) begin
               mShDiv[k] = divV;
               mShEn[k]  = enV;
               mState[k] = 2;
            end
         end
         default: begin
            mDiv[k]   = mShDiv[k];
            mOut[k]   = 1'b0;
            mLeft[k]  = mDiv[k] + 1;
            mState[k] = 1;
         end
      endcase
   endtask

   task automatic check(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Compare every output of both instances with the model.
   task automatic checkOutput();
      bit busyExpA;
      bit busyExpB;
      busyExpA = (mState[0] >= 2);
      busyExpB = (mState[1] >= 2);
      check("A.clk_out",   clkOutA,        mOut[0]);
      check("A.tick",      tickA,          mTick[0]);
      check("A.busy",      busyA,          busyExpA);
      check("A.cfg_ready", cfgA.cfg_ready, !busyExpA);
      check("B.clk_out",   clkOutB,        mOut[1]);
      check("B.tick",      tickB,          mTick[1]);
      check("B.busy",      busyB,          busyExpB);
   endtask

   // One clock: drive inputs, take the edge, step the model, compare.
   task automatic applyStimulus(bit ceV, bit validV, int divV, bit enV);
      ce             = ceV;
      cfgA.cfg_valid = validV;
      cfgA.cfg_div   = W'(divV);
      cfgA.cfg_en    = enV;
      @(posedge clk);
      modelEdge(0, ceV, validV, divV, enV);
      modelEdge(1, ceV, 1'b0, 0, 1'b0);
      #1;
      checkOutput();
   endtask

   task automatic idle(int n, bit ceV);
      for (int i = 0; i < n; i++) applyStimulus(ceV, 1'b0, 0, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      ce             = 1'b0;
      cfgA.cfg_valid = 1'b0;
      cfgA.cfg_div   = '0;
      cfgA.cfg_en    = 1'b0;
      cfgB.cfg_valid = 1'b0;
      cfgB.cfg_div   = '0;
      cfgB.cfg_en    = 1'b0;
      modelReset();
      #100;
      checkOutput();
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset released");

      // Fastest ratio: period of two clocks, tick every second cycle.
      applyStimulus(1'b1, 1'b1, 0, 1'b1);
      idle(12, 1'b1);

      // Switch to div=3, then request div=1 while the output is high.
      applyStimulus(1'b1, 1'b1, 3, 1'b1);
      idle(12, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (mOut[0] && mState[0] == 1 && mLeft[0] == 2) break;
         applyStimulus(1'b1, 1'b0, 0, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1, 1'b1);
      idle(20, 1'b1);

      // Run at div=2 then ask to stop; the output finishes its period.
      applyStimulus(1'b1, 1'b1, 2, 1'b1);
      idle(15, 1'b1);
      applyStimulus(1'b1, 1'b1, 5, 1'b0);
      idle(20, 1'b1);

      // Half-rate ce with div=1, then a request stalled by ce=0.
      applyStimulus(1'b1, 1'b1, 1, 1'b1);
      for (int i = 0; i < 30; i++) applyStimulus(i[0], 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 2, 1'b1);
      idle(6, 1'b0);
      idle(12, 1'b1);

      // Asynchronous reset while a request is pending.
      applyStimulus(1'b1, 1'b1, 4, 1'b1);
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      rst = 1'b1;
      #1;
      check("rst.clk_out", clkOutA, 1'b0);
      check("rst.tick",    tickA,   1'b0);
      check("rst.busy",    busyA,   1'b0);
      check("rst.ready",   cfgA.cfg_ready, 1'b1);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(12, 1'b1);

      // Request held valid continuously.
      for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1, 1, 1'b1);
      idle(6, 1'b1);

      // Largest legal ratio, then back to the fastest.
      applyStimulus(1'b1, 1'b1, (1 << W) - 1, 1'b1);
      idle(1030, 1'b1);
      applyStimulus(1'b1, 1'b1, 0, 1'b1);
      idle(520, 1'b1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 4)),
                       $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
